// File: rtl/out_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : out_uart_pkg
// Desc   : Shared ASCII constants, FSM state types and hex-digit encoder for
//          the output-register UART trace.
// Rev    : 1.0
// ============================================================================
package out_uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } top_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_0 + {4'h0, nib};
    return ASCII_A + {4'h0, nib} - 8'd10;
  endfunction

endpackage
`default_nettype wire

// File: rtl/out_reg_uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_byte
// Desc   : 8N1 byte serializer; done pulses in the last stop-bit cycle.
// Rev    : 1.0
// ============================================================================
module uart_tx_byte
  import out_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       s_reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign tx      = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    done    = 1'b0;
    tx_d    = 1'b1;
    if (state_q != TX_IDLE) cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    unique case (state_q)
      TX_IDLE: begin
        if (start) begin
          state_d = TX_START;
          cnt_d   = '0;
          shreg_d = data;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          idx_d   = '0;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (idx_q == 3'd7) state_d = TX_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      TX_STOP: begin
        // A start in the final stop cycle chains the next byte with no gap.
        if (bit_end) begin
          done = 1'b1;
          if (start) begin
            state_d = TX_START;
            shreg_d = data;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
    unique case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shreg_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (s_reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/out_reg_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : out_reg_uart_tx
// Desc   : Sends each output-register load as uppercase hex + CR LF over UART.
//          OUT_UART_DEDUP_EN drops words equal to the last one sent.
// Rev    : 1.0
// ============================================================================
module out_reg_uart_tx
  import out_uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic                  clk,
  input  logic                  s_reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  tx,
  output logic                  busy,
  output logic                  overrun
);

  localparam int               CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int               NCHAR        = DATA_WIDTH / 4;
  localparam int               IDX_W        = $clog2(NCHAR + 3);
  localparam logic [IDX_W-1:0] IDX_HEX_END  = IDX_W'(NCHAR);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NCHAR + 2);

  top_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pend_full_q, pend_full_d;
  logic [DATA_WIDTH-1:0] pend_word_q, pend_word_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic                  ser_start;
  logic                  ser_done;
  logic [7:0]            ser_data;
  logic                  dup;
  logic                  consume;
  logic                  to_pend;

  assign busy    = busy_q;
  assign overrun = overrun_q;

  always_comb begin
    ser_data = ASCII_LF;
    if (idx_q < IDX_HEX_END)       ser_data = nib2ascii(shift_q[DATA_WIDTH-1 -: 4]);
    else if (idx_q == IDX_HEX_END) ser_data = ASCII_CR;
  end

  // LOAD launches the first char; later chars are chained from SEND on done
  // so the serializer sees start in its final stop cycle and leaves no gap.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    ser_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_full_q) begin
          state_d = LOAD;
          shift_d = pend_word_q;
          idx_d   = '0;
        end else if (data_valid && !dup) begin
          state_d = LOAD;
          shift_d = data_in;
          idx_d   = '0;
        end
      end
      LOAD: begin
        ser_start = 1'b1;
        state_d   = SEND;
      end
      SEND: begin
        if (ser_done) begin
          if (idx_q == IDX_LAST) state_d   = IDLE;
          else                   ser_start = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (ser_start) begin
      idx_d = idx_q + IDX_W'(1);
      if (idx_q < IDX_HEX_END) shift_d = shift_q << 4;
    end
  end

  assign consume = (state_q == IDLE) && pend_full_q;
  assign to_pend = data_valid && !dup && ((state_q != IDLE) || pend_full_q);

  always_comb begin
    pend_full_d = pend_full_q;
    pend_word_d = pend_word_q;
    overrun_d   = 1'b0;
    if (consume) pend_full_d = 1'b0;
    if (to_pend) begin
      pend_full_d = 1'b1;
      pend_word_d = data_in;
      overrun_d   = pend_full_q && !consume;
    end
    busy_d = (state_d != IDLE) || pend_full_d;
  end

`ifdef OUT_UART_DEDUP_EN
  logic [DATA_WIDTH-1:0] last_sent_q, last_sent_d;

  assign dup = (data_in == last_sent_q);

  always_comb begin
    last_sent_d = last_sent_q;
    if (state_q == IDLE && state_d == LOAD) last_sent_d = shift_d;
  end

  always_ff @(posedge clk) begin
    if (s_reset) last_sent_q <= '0;
    else         last_sent_q <= last_sent_d;
  end
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (s_reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      pend_full_q <= 1'b0;
      pend_word_q <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      pend_full_q <= pend_full_d;
      pend_word_q <= pend_word_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk    (clk),
    .s_reset(s_reset),
    .start  (ser_start),
    .data   (ser_data),
    .tx     (tx),
    .done   (ser_done)
  );

endmodule
`default_nettype wire
